decode_pipe: RTL
================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter AWIDTH, default 5, register address width; fixed at 5 for MIPS field positions.
REQ-002 Parameter DWIDTH, default 32, width of extended immediate; SHALL be >= 32.
REQ-003 Parameter PCWIDTH, default 32, width of carried program counter.
REQ-004 d_clk  in  1  clock, all state updates on rising edge.
REQ-005 d_rst  in  1  reset, synchronous, active-high.
REQ-006 d_i_valid  in  1  upstream instruction valid.
REQ-007 d_o_ready  out  1  block can accept an instruction this cycle.
REQ-008 d_i_instr  in  32  instruction word; d_i_pc  in  PCWIDTH  its PC.
REQ-009 d_i_flush  in  1  discard all held and incoming instructions.
REQ-010 d_o_valid  out  1  decoded bundle valid; d_i_ready  in  1  downstream accepts.
REQ-011 d_o_opcode  out  6; d_o_funct  out  6; d_o_shamt  out  5.
REQ-012 d_o_addr_rs, d_o_addr_rt, d_o_addr_rd  out  AWIDTH  source/dest fields.
REQ-013 d_o_imm  out  DWIDTH  extended immediate; d_o_jaddr  out  26  jump target field.
REQ-014 d_o_wr_en  out  1 and d_o_wr_addr  out  AWIDTH  register write-back request and target.
REQ-015 d_o_illegal  out  1  unsupported opcode/funct; d_o_pc  out  PCWIDTH  PC of bundle.

Function
REQ-016 in_fire = d_i_valid & d_o_ready; out_fire = d_o_valid & d_i_ready.
REQ-017 Storage SHALL be one output register plus one skid register; states EMPTY, BUSY (output held), FULL (output and skid held).
REQ-018 d_o_ready SHALL be 0 while d_rst high, else (state != FULL); it SHALL NOT depend combinationally on d_i_ready.
REQ-019 EMPTY: in_fire -> load output, BUSY.
REQ-020 BUSY: in_fire & out_fire -> load output, stay BUSY; in_fire & !out_fire -> load skid, FULL; out_fire only -> EMPTY.
REQ-021 FULL: out_fire -> output <= skid, BUSY; otherwise hold.
REQ-022 Latency SHALL be 1 cycle from in_fire (in EMPTY/BUSY-with-out_fire) to d_o_valid; order SHALL be preserved, no drop, no duplication.
REQ-023 Output bundle SHALL remain stable while d_o_valid & !d_i_ready.
REQ-024 d_i_flush (when d_rst low) SHALL force EMPTY, d_o_valid=0, and discard any instruction presented that cycle; flush overrides in_fire/out_fire.
REQ-025 Decode is combinational on d_i_instr, registered on capture; rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
REQ-026 Opcodes: RTYPE 0x00, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, LW 0x23, SW 0x2B.
REQ-027 Legal R-type funct: 0x00,0x02,0x03,0x08,0x20-0x27,0x2A,0x2B.
REQ-028 d_o_imm: sign-extend [15:0] for ADDI/ADDIU/SLTI/SLTIU/LW/SW/BEQ/BNE; zero-extend for ANDI/ORI/XORI; LUI -> [15:0] in bits [31:16], other bits 0; all else 0.
REQ-029 d_o_jaddr = [25:0] for J/JAL, else 0.
REQ-030 Write-back: R-type (except JR) -> rd; I-ALU, LUI, LW -> rt; JAL -> 31; SW, BEQ, BNE, J, JR -> wr_en=0.
REQ-031 d_o_wr_en SHALL be 0 whenever d_o_wr_addr would be 0; d_o_wr_addr=0 when wr_en=0.
REQ-032 Illegal opcode or R-type funct: bundle valid, d_o_illegal=1, d_o_pc kept, all other fields 0.
REQ-033 Field outputs SHALL be 0 whenever d_o_valid=0 (including after flush).

Reset
REQ-034 d_rst high at an edge: state EMPTY, skid cleared, every output register (d_o_valid, fields, d_o_imm, d_o_pc, d_o_illegal, d_o_wr_en) = 0; reset mid-transfer drops held instructions.
REQ-035 Reset SHALL override flush and all handshake activity.

Verification
REQ-036 Single ADDI 0x2001FFFF, pc 0x100, d_i_ready=1 -> next cycle valid, rt=1, imm=0xFFFFFFFF, wr_en=1, wr_addr=1, pc=0x100.
REQ-037 ORI 0x3402_8000 -> imm=0x00008000; LUI 0x3C03_1234 -> imm=0x12340000, wr_addr=3.
REQ-038 Back-to-back 3 instructions with d_i_ready=0 for 3 cycles -> state FULL, d_o_ready=0, first output stable; release -> outputs in order, none lost.
REQ-039 JAL 0x0C00_0010 -> jaddr=0x10, wr_addr=31; SW 0xAC22_0004 -> wr_en=0, imm=4; R-type with rd=0 -> wr_en=0.
REQ-040 Opcode 0x3F or R-type funct 0x01 -> valid, illegal=1, other fields 0 except pc.
REQ-041 Flush while FULL with d_i_valid=1 -> next cycle d_o_valid=0, d_o_ready=1, neither held nor incoming instruction emerges; reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: MIPS-style instruction decoder. The decode is combinational on
// the incoming word and captured into a one-entry output register backed by a
// one-entry skid register. Because of the skid entry, d_o_ready depends only on
// the registered state (and d_rst), never on d_i_ready.
module decode_pipe #(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = 32,
  parameter int PCWIDTH = 32
) (
  input  logic               d_clk,
  input  logic               d_rst,
  input  logic               d_i_valid,
  output logic               d_o_ready,
  input  logic [31:0]        d_i_instr,
  input  logic [PCWIDTH-1:0] d_i_pc,
  input  logic               d_i_flush,
  output logic               d_o_valid,
  input  logic               d_i_ready,
  output logic [5:0]         d_o_opcode,
  output logic [5:0]         d_o_funct,
  output logic [4:0]         d_o_shamt,
  output logic [AWIDTH-1:0]  d_o_addr_rs,
  output logic [AWIDTH-1:0]  d_o_addr_rt,
  output logic [AWIDTH-1:0]  d_o_addr_rd,
  output logic [DWIDTH-1:0]  d_o_imm,
  output logic [25:0]        d_o_jaddr,
  output logic               d_o_wr_en,
  output logic [AWIDTH-1:0]  d_o_wr_addr,
  output logic               d_o_illegal,
  output logic [PCWIDTH-1:0] d_o_pc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // One decoded instruction as it travels through the output/skid registers.
  typedef struct packed {
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         shamt;
    logic [AWIDTH-1:0]  rs;
    logic [AWIDTH-1:0]  rt;
    logic [AWIDTH-1:0]  rd;
    logic [DWIDTH-1:0]  imm;
    logic [25:0]        jaddr;
    logic               wr_en;
    logic [AWIDTH-1:0]  wr_addr;
    logic               illegal;
    logic [PCWIDTH-1:0] pc;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Immediate extension helpers.
  function automatic logic signed [DWIDTH-1:0] sext16(input logic signed [15:0] v);
    return DWIDTH'(v);
  endfunction

  function automatic logic [DWIDTH-1:0] zext16(input logic [15:0] v);
    return DWIDTH'(v);
  endfunction

  function automatic logic [DWIDTH-1:0] lui16(input logic [15:0] v);
    return DWIDTH'({v, 16'h0000});
  endfunction

  state_t            state;
  logic              vld_p1;
  bundle_t           out_p1;
  bundle_t           skid_p1;
  bundle_t           dec_p0;
  logic [5:0]        op_p0;
  logic [5:0]        fn_p0;
  logic              op_legal_p0;
  logic              fn_legal_p0;
  logic [AWIDTH-1:0] wa_p0;
  logic              in_fire;
  logic              out_fire;

  assign op_p0 = d_i_instr[31:26];
  assign fn_p0 = d_i_instr[5:0];

  // ---- stage p0: combinational decode of the presented instruction ----
  always_comb begin
    op_legal_p0 = 1'b0;
    case (op_p0)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
        op_legal_p0 = 1'b1;
      default: op_legal_p0 = 1'b0;
    endcase

    fn_legal_p0 = 1'b0;
    case (fn_p0)
      6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B:
        fn_legal_p0 = 1'b1;
      default: fn_legal_p0 = 1'b0;
    endcase

    wa_p0     = '0;
    dec_p0    = '0;
    dec_p0.pc = d_i_pc;

    if (!op_legal_p0 || ((op_p0 == OP_RTYPE) && !fn_legal_p0)) begin
      // Illegal words carry only their PC and the flag.
      dec_p0.illegal = 1'b1;
    end else begin
      dec_p0.opcode = op_p0;
      dec_p0.funct  = fn_p0;
      dec_p0.shamt  = d_i_instr[10:6];
      dec_p0.rs     = d_i_instr[25:21];
      dec_p0.rt     = d_i_instr[20:16];
      dec_p0.rd     = d_i_instr[15:11];

      case (op_p0)
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE:
          dec_p0.imm = sext16(d_i_instr[15:0]);
        OP_ANDI, OP_ORI, OP_XORI:
          dec_p0.imm = zext16(d_i_instr[15:0]);
        OP_LUI:
          dec_p0.imm = lui16(d_i_instr[15:0]);
        default: dec_p0.imm = '0;
      endcase

      if ((op_p0 == OP_J) || (op_p0 == OP_JAL))
        dec_p0.jaddr = d_i_instr[25:0];

      case (op_p0)
        OP_RTYPE:
          wa_p0 = (fn_p0 == FN_JR) ? '0 : d_i_instr[15:11];
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
        OP_LUI, OP_LW:
          wa_p0 = d_i_instr[20:16];
        OP_JAL:
          wa_p0 = AWIDTH'(31);
        default: wa_p0 = '0;
      endcase

      // A write to register 0 is no write at all.
      dec_p0.wr_en   = |wa_p0;
      dec_p0.wr_addr = wa_p0;
    end
  end

  assign d_o_ready = !d_rst && (state != FULL);
  assign in_fire   = d_i_valid && d_o_ready;
  assign out_fire  = vld_p1 && d_i_ready;

  // ---- stage p1: output register with skid entry; reset and flush empty both ----
  always_ff @(posedge d_clk) begin
    if (d_rst || d_i_flush) begin
      state   <= EMPTY;
      vld_p1  <= 1'b0;
      out_p1  <= '0;
      skid_p1 <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            out_p1 <= dec_p0;
            vld_p1 <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            out_p1 <= dec_p0;
          end else if (in_fire) begin
            skid_p1 <= dec_p0;
            state   <= FULL;
          end else if (out_fire) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_p1  <= skid_p1;
            skid_p1 <= '0;
            state   <= BUSY;
          end
        end
        default: begin
          state   <= EMPTY;
          vld_p1  <= 1'b0;
          out_p1  <= '0;
          skid_p1 <= '0;
        end
      endcase
    end
  end

  assign d_o_valid   = vld_p1;
  assign d_o_opcode  = out_p1.opcode;
  assign d_o_funct   = out_p1.funct;
  assign d_o_shamt   = out_p1.shamt;
  assign d_o_addr_rs = out_p1.rs;
  assign d_o_addr_rt = out_p1.rt;
  assign d_o_addr_rd = out_p1.rd;
  assign d_o_imm     = out_p1.imm;
  assign d_o_jaddr   = out_p1.jaddr;
  assign d_o_wr_en   = out_p1.wr_en;
  assign d_o_wr_addr = out_p1.wr_addr;
  assign d_o_illegal = out_p1.illegal;
  assign d_o_pc      = out_p1.pc;

endmodule
